// File: rtl/execute_out_fifo.sv
// In-order buffer between the LC3 execute stage and its writeback/memaccess consumers.
// Captures the execute_out bundle on push, presents the head through valid/ready.
module execute_out_fifo #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int DEPTH          = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable_execute_out,
  input  logic [1:0]                W_Control_out,
  input  logic                      Mem_Control_out,
  input  logic [REG_ADDR_WIDTH-1:0] sr1,
  input  logic [REG_ADDR_WIDTH-1:0] sr2,
  input  logic [REG_ADDR_WIDTH-1:0] dr,
  input  logic [2:0]                NZP,
  input  logic [DATA_WIDTH-1:0]     aluout,
  input  logic [DATA_WIDTH-1:0]     pcout,
  input  logic [DATA_WIDTH-1:0]     M_Data,
  input  logic [DATA_WIDTH-1:0]     IR_Exec,
  input  logic                      flush,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [1:0]                out_W_Control,
  output logic                      out_Mem_Control,
  output logic [REG_ADDR_WIDTH-1:0] out_sr1,
  output logic [REG_ADDR_WIDTH-1:0] out_sr2,
  output logic [REG_ADDR_WIDTH-1:0] out_dr,
  output logic [2:0]                out_NZP,
  output logic [DATA_WIDTH-1:0]     out_aluout,
  output logic [DATA_WIDTH-1:0]     out_pcout,
  output logic [DATA_WIDTH-1:0]     out_M_Data,
  output logic [DATA_WIDTH-1:0]     out_IR_Exec,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [1:0]                w_control;
    logic                      mem_control;
    logic [REG_ADDR_WIDTH-1:0] sr1;
    logic [REG_ADDR_WIDTH-1:0] sr2;
    logic [REG_ADDR_WIDTH-1:0] dr;
    logic [2:0]                nzp;
    logic [DATA_WIDTH-1:0]     aluout;
    logic [DATA_WIDTH-1:0]     pcout;
    logic [DATA_WIDTH-1:0]     m_data;
    logic [DATA_WIDTH-1:0]     ir_exec;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          wr_entry;
  entry_t          head;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            full, push, pop;

  always_comb begin
    full      = (count_q == FULL_CNT);
    in_ready  = !full;
    out_valid = (count_q != '0);
    push      = enable_execute_out && !full;
    pop       = out_valid && out_ready;

    wr_entry.w_control   = W_Control_out;
    wr_entry.mem_control = Mem_Control_out;
    wr_entry.sr1         = sr1;
    wr_entry.sr2         = sr2;
    wr_entry.dr          = dr;
    wr_entry.nzp         = NZP;
    wr_entry.aluout      = aluout;
    wr_entry.pcout       = pcout;
    wr_entry.m_data      = M_Data;
    wr_entry.ir_exec     = IR_Exec;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    // A push attempt while full is recorded even if a flush happens alongside.
    overflow_d = overflow_q | (enable_execute_out && full);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately left unreset; validity comes from count_q alone.
  always_ff @(posedge clock) begin
    if (!reset && !flush && push) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_comb begin
    head            = out_valid ? mem_q[rd_ptr_q] : '0;
    out_W_Control   = head.w_control;
    out_Mem_Control = head.mem_control;
    out_sr1         = head.sr1;
    out_sr2         = head.sr2;
    out_dr          = head.dr;
    out_NZP         = head.nzp;
    out_aluout      = head.aluout;
    out_pcout       = head.pcout;
    out_M_Data      = head.m_data;
    out_IR_Exec     = head.ir_exec;
    count           = count_q;
    overflow        = overflow_q;
  end

endmodule

// File: tb/tb_execute_out_fifo.sv
// Scoreboard bench for execute_out_fifo: stimulus queues expected heads,
// a negedge monitor pops and compares on every accepted handshake.
module tb_execute_out_fifo;

  logic        clock = 1'b0;
  logic        reset, enable_execute_out, flush, out_ready;
  logic [1:0]  W_Control_out;
  logic        Mem_Control_out;
  logic [2:0]  sr1, sr2, dr, NZP;
  logic [15:0] aluout, pcout, M_Data, IR_Exec;
  logic        in_ready, out_valid;
  logic [1:0]  out_W_Control;
  logic        out_Mem_Control;
  logic [2:0]  out_sr1, out_sr2, out_dr, out_NZP;
  logic [15:0] out_aluout, out_pcout, out_M_Data, out_IR_Exec;
  logic [2:0]  count;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];   // {pcout, aluout}

  always #5 clock = ~clock;

  execute_out_fifo #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(3), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .enable_execute_out(enable_execute_out),
    .W_Control_out(W_Control_out), .Mem_Control_out(Mem_Control_out),
    .sr1(sr1), .sr2(sr2), .dr(dr), .NZP(NZP), .aluout(aluout), .pcout(pcout),
    .M_Data(M_Data), .IR_Exec(IR_Exec), .flush(flush), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_W_Control(out_W_Control),
    .out_Mem_Control(out_Mem_Control), .out_sr1(out_sr1), .out_sr2(out_sr2),
    .out_dr(out_dr), .out_NZP(out_NZP), .out_aluout(out_aluout),
    .out_pcout(out_pcout), .out_M_Data(out_M_Data), .out_IR_Exec(out_IR_Exec),
    .count(count), .overflow(overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_push(input logic [15:0] a, input logic [15:0] p, input logic expect_accept);
    enable_execute_out = 1'b1;
    aluout = a;
    pcout  = p;
    if (expect_accept) sb_q.push_back({p, a});
  endtask

  // Monitor: a handshake at the coming edge is visible at the negedge before it.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_output", {out_pcout, out_aluout}, 32'hFFFF_FFFF);
      end else begin
        chk("head_order", {out_pcout, out_aluout}, sb_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable_execute_out = 1'b0; flush = 1'b0; out_ready = 1'b0;
    W_Control_out = 2'b00; Mem_Control_out = 1'b0; sr1 = '0; sr2 = '0; dr = '0;
    NZP = '0; aluout = '0; pcout = '0; M_Data = '0; IR_Exec = '0;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_aluout", 32'(out_aluout), 0);

    // Single entry: all fields appear one cycle after the push.
    dr = 3'd3; NZP = 3'b010; IR_Exec = 16'h1263; W_Control_out = 2'b10;
    drive_push(16'h1234, 16'h3001, 1'b1);
    step();
    enable_execute_out = 1'b0;
    chk("one_valid", 32'(out_valid), 1);
    chk("one_aluout", 32'(out_aluout), 32'h1234);
    chk("one_pcout", 32'(out_pcout), 32'h3001);
    chk("one_dr", 32'(out_dr), 3);
    chk("one_nzp", 32'(out_NZP), 32'b010);
    chk("one_ir", 32'(out_IR_Exec), 32'h1263);
    chk("one_wctl", 32'(out_W_Control), 2);
    chk("one_count", 32'(count), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("one_drained", 32'(count), 0);

    // Fill, attempt overflow, drain in order.
    for (int i = 1; i <= 4; i++) begin
      drive_push(16'(i), 16'h3000 + 16'(i), 1'b1);
      step();
    end
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_count", 32'(count), 4);
    drive_push(16'h0005, 16'h3005, 1'b0);
    step();
    enable_execute_out = 1'b0;
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 4);
    out_ready = 1'b1;
    repeat (4) step();
    out_ready = 1'b0;
    chk("drain_count", 32'(count), 0);
    chk("drain_ovf_sticky", 32'(overflow), 1);
    chk("drain_sb_empty", 32'(sb_q.size()), 0);

    // Streaming with a pop every cycle, across pointer wrap.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_push(16'h0010 + 16'(i), 16'h4000 + 16'(i), 1'b1);
      step();
      chk("stream_count", 32'(count), 1);
    end
    enable_execute_out = 1'b0;
    step();
    out_ready = 1'b0;
    chk("stream_end_count", 32'(count), 0);
    chk("stream_sb_empty", 32'(sb_q.size()), 0);

    // Flush with concurrent push and pop.
    for (int i = 0; i < 3; i++) begin
      drive_push(16'h0030 + 16'(i), 16'h5000 + 16'(i), 1'b1);
      step();
    end
    chk("preflush_count", 32'(count), 3);
    flush = 1'b1; out_ready = 1'b1;
    drive_push(16'h00AA, 16'h50AA, 1'b0);
    step();
    flush = 1'b0; enable_execute_out = 1'b0;
    sb_q.delete();
    chk("flush_count", 32'(count), 0);
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_ovf_kept", 32'(overflow), 1);
    chk("flush_aluout", 32'(out_aluout), 0);
    repeat (3) step();
    out_ready = 1'b0;
    chk("postflush_count", 32'(count), 0);

    // Reset mid-stream overrides a concurrent push.
    drive_push(16'h0020, 16'h6000, 1'b1);
    step();
    drive_push(16'h0021, 16'h6001, 1'b1);
    step();
    enable_execute_out = 1'b0;
    chk("prerst_count", 32'(count), 2);
    chk("prerst_ovf", 32'(overflow), 1);
    reset = 1'b1;
    drive_push(16'h0022, 16'h6002, 1'b0);
    step();
    reset = 1'b0; enable_execute_out = 1'b0;
    sb_q.delete();
    chk("midrst_count", 32'(count), 0);
    chk("midrst_ovf", 32'(overflow), 0);
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_aluout", 32'(out_aluout), 0);
    chk("midrst_pcout", 32'(out_pcout), 0);
    chk("midrst_dr", 32'(out_dr), 0);
    chk("midrst_ir", 32'(out_IR_Exec), 0);
    step();
    chk("postrst_in_ready", 32'(in_ready), 1);
    chk("postrst_count", 32'(count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_out_fifo.md
Name: execute_out_fifo

Overview:
- Parametrised buffer between the LC3 execute stage and the writeback/memaccess consumers.
- Captures the full execute_out bundle on each `enable_execute_out` strobe: control, register addresses, NZP, aluout, pcout, M_Data and IR_Exec.
- Holds up to DEPTH entries.
- Presents entries in order through a valid/ready handshake, so downstream stalls do not drop execute results.
- Adds flush, occupancy and sticky overflow reporting.

Parameters:
- DATA_WIDTH, 16, width of aluout, pcout, M_Data and IR_Exec fields.
- REG_ADDR_WIDTH, 3, width of sr1, sr2 and dr.
- DEPTH, 4, number of entries; power of two, minimum 2.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- enable_execute_out  input  1  push strobe; entry captured when high and in_ready high.
- W_Control_out  input  2  writeback control field.
- Mem_Control_out  input  1  memory control field.
- sr1  input  REG_ADDR_WIDTH  source register 1.
- sr2  input  REG_ADDR_WIDTH  source register 2.
- dr  input  REG_ADDR_WIDTH  destination register.
- NZP  input  3  condition codes.
- aluout  input  DATA_WIDTH  ALU result.
- pcout  input  DATA_WIDTH  computed PC.
- M_Data  input  DATA_WIDTH  store data.
- IR_Exec  input  DATA_WIDTH  executed instruction.
- flush  input  1  synchronous discard of all entries.
- in_ready  output  1  high when count < DEPTH.
- out_valid  output  1  head entry present.
- out_ready  input  1  consumer accepts head when out_valid high.
- out_W_Control, out_Mem_Control, out_sr1, out_sr2, out_dr, out_NZP, out_aluout, out_pcout, out_M_Data, out_IR_Exec  output  matching input widths  head entry fields.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky flag: push attempted while full.

Behaviour:
- Reset, synchronous on clock when reset=1:
  - Pointers and count go to 0, and overflow goes to 0.
  - out_valid goes to 0 and all out_* fields go to 0.
  - in_ready goes to 1 in the cycle after reset deasserts.
  - Reset overrides flush and push in the same cycle.
- Push: `enable_execute_out` && in_ready at a rising edge writes the bundle at wr_ptr; wr_ptr then increments modulo DEPTH.
- Pop: out_valid && out_ready at a rising edge increments rd_ptr modulo DEPTH.
- Latency:
  - A push into an empty FIFO raises out_valid, with the fields, on the following cycle.
  - There is no combinational path from the inputs to the out_* fields.
- Head fields:
  - out_* fields reflect the entry at rd_ptr whenever out_valid=1.
  - They are driven to 0 when out_valid=0.
- Count update:
  - count = count + push − pop.
  - Simultaneous push and pop leaves count unchanged and accepts both.
- in_ready timing:
  - in_ready depends only on registered count, never on out_ready.
  - When full, a push is refused even if a pop occurs in the same cycle.
- Full behaviour: with count == DEPTH and `enable_execute_out` high:
  - Data is dropped and no state changes except overflow <= 1.
  - overflow clears only on reset.
- Empty behaviour: out_ready with out_valid=0 is ignored, and count never underflows.
- Flush:
  - Pointers and count go to 0 next cycle and out_valid goes to 0.
  - A push and pop in the same cycle as flush are discarded.
  - overflow is unaffected.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally; order is preserved across the wrap.
- Storage:
  - Registered array of DEPTH entries, each 6+3·REG_ADDR_WIDTH+4·DATA_WIDTH bits.
  - Storage contents are not reset; only control state is.

Test Plan:
- After reset, with `enable_execute_out`=0: expect count=0, out_valid=0, in_ready=1, overflow=0, out_aluout=0x0000.
- Push one entry {aluout=0x1234, pcout=0x3001, dr=3, NZP=3'b010, IR_Exec=0x1263} with out_ready=0: next cycle expect out_valid=1, out_aluout=0x1234, out_dr=3, count=1.
- Push 4 entries (aluout 0x0001..0x0004) with out_ready=0, then push 0x0005: expect in_ready=0 after the fourth push, the fifth dropped, overflow=1. Then pop 4: expect 0x0001..0x0004 in order, final count=0, overflow still 1.
- Hold out_ready=1 and push every cycle for 10 cycles (aluout 0x0010..0x0019): expect count steady at 1 and outputs 0x0010..0x0019 in order, one per cycle, across pointer wrap.
- With 3 entries held, assert flush together with push 0x00AA and out_ready=1: next cycle expect count=0, out_valid=0, and 0x00AA never appears.
- Assert reset mid-stream with count=2, overflow=1: next cycle expect count=0, overflow=0, out_valid=0, all out_* fields 0.
